start_light_sequencer: RTL and testbench

START_LIGHT_SEQUENCER -- requirements
Module: start_light_sequencer

---
 rtl/start_light_pkg.sv | 38 +++
 rtl/start_light_sequencer_lfsr.sv | 39 +++
 rtl/start_light_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_start_light_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/start_light_pkg.sv
// Shared types and constants for the start-light sequencer: FSM state encoding,
// LFSR seed and feedback-tap lookup for widths 8..16.
package start_light_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StArmed,
      StLeds,
      StDelay,
      StGo,
      StFault
   } state_e;

   localparam int unsigned LFSR_MIN_W = 8;
   localparam int unsigned LFSR_MAX_W = 16;

   // Nonzero seed; the LFSR can never fall into the all-zero lock-up state.
   localparam logic [LFSR_MAX_W-1:0] LFSR_SEED = 16'h0001;

   // Galois feedback masks (bit t-1 set for polynomial tap t); the top bit is
   // always set, which keeps a nonzero state nonzero after every shift.
   function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int unsigned width);
      logic [LFSR_MAX_W-1:0] taps;
      case (width)
         8:       taps = 16'h00B8;
         9:       taps = 16'h0110;
         10:      taps = 16'h0240;
         11:      taps = 16'h0500;
         12:      taps = 16'h0829;
         13:      taps = 16'h100D;
         14:      taps = 16'h2015;
         15:      taps = 16'h6000;
         default: taps = 16'hD008;
      endcase
      return taps;
   endfunction

endpackage

// File: rtl/start_light_sequencer_lfsr.sv
// Galois pseudo-random sequence generator with enable and synchronous seed reset.
module prbs_lfsr
   import start_light_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] state
);

   localparam logic [LFSR_MAX_W-1:0] TAPS_FULL = lfsr_taps(WIDTH);
   localparam logic [WIDTH-1:0]      TAPS      = TAPS_FULL[WIDTH-1:0];
   localparam logic [WIDTH-1:0]      SEED      = LFSR_SEED[WIDTH-1:0];

   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] lfsr_d;

   // Shift right and fold in the taps when the outgoing bit is set; hold when disabled.
   always_comb begin
      lfsr_d = lfsr_q;
      if (en) begin
         lfsr_d = (lfsr_q >> 1) ^ ({WIDTH{lfsr_q[0]}} & TAPS);
      end
   end

   // State register with synchronous reseed.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state = lfsr_q;

endmodule

// File: rtl/start_light_sequencer.sv
// Start-light sequencer: arms, fills the light bar one step at a time, waits a
// pseudo-random delay, then times the competitor's reaction in i_tick units.
// Optional feature macro: FALSE_START_DETECT_EN (reaction before GO -> FAULT).
module start_light_sequencer
   import start_light_pkg::*;
#(
   parameter int unsigned N_LEDS     = 10,
   parameter int unsigned STEP_TICKS = 1,
   parameter int unsigned DELAY_W    = 8,
   parameter int unsigned MIN_DELAY  = 16,
   parameter int unsigned TIME_W     = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_tick,
   input  logic              i_trigger,
   input  logic              i_reaction,
   output logic [N_LEDS-1:0] o_lights,
   output logic              o_go,
   output logic              o_falseStart,
   output logic              o_resultValid,
   output logic [TIME_W-1:0] o_reactionTime
);

   localparam int unsigned LFSR_W = (DELAY_W > LFSR_MIN_W) ? DELAY_W : LFSR_MIN_W;
   // One spare bit beyond the largest loadable delay.
   localparam int unsigned DCNT_W = $clog2(MIN_DELAY + (1 << DELAY_W)) + 1;
   localparam int unsigned STEP_W = 8;

   localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(STEP_TICKS - 1);
   localparam logic [N_LEDS-1:0] ALL_ON      = '1;
   localparam logic [DCNT_W-1:0] DELAY_FLOOR = DCNT_W'(MIN_DELAY);

   state_e              state_q, state_d;
   logic [N_LEDS-1:0]   lights_q, lights_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [DCNT_W-1:0]   delay_q, delay_d;
   logic [TIME_W-1:0]   react_q, react_d;
   logic [TIME_W-1:0]   time_q, time_d;
   logic                valid_q, valid_d;

   logic                lfsr_en;
   logic [LFSR_W-1:0]   lfsr_val;
   logic [N_LEDS-1:0]   lights_next;
   logic [DCNT_W-1:0]   delay_load;
   logic                false_start;
   logic                unused_lfsr;

   prbs_lfsr #(
      .WIDTH (LFSR_W)
   ) u_lfsr (
      .clk   (i_clk),
      .rst   (i_rst),
      .en    (lfsr_en),
      .state (lfsr_val)
   );

   // Only the low DELAY_W bits feed the delay; the rest just keep the sequence long.
   assign unused_lfsr = ^lfsr_val;

`ifdef FALSE_START_DETECT_EN
   assign false_start = i_reaction;
`else
   assign false_start = 1'b0;
`endif

   assign lights_next = {lights_q[N_LEDS-2:0], 1'b1};
   assign delay_load  = DELAY_FLOOR + DCNT_W'(lfsr_val[DELAY_W-1:0]);

   // Next-state and datapath updates for the sequence FSM.
   always_comb begin
      state_d = state_q;
      lights_d = lights_q;
      step_d = step_q;
      delay_d = delay_q;
      react_d = react_q;
      time_d = time_q;
      valid_d = 1'b0;
      lfsr_en = 1'b0;

      unique case (state_q)
         StIdle: begin
            lights_d = '0;
            step_d = '0;
            delay_d = '0;
            state_d = StArmed;
         end

         StArmed: begin
            // LFSR only runs while waiting, so the delay depends on human timing.
            lfsr_en = 1'b1;
            if (i_trigger) begin
               lights_d = '0;
               step_d = '0;
               state_d = StLeds;
            end
         end

         StLeds: begin
            if (false_start) begin
               lights_d = ALL_ON;
               state_d = StFault;
            end else if (i_tick) begin
               if (step_q == STEP_LAST) begin
                  step_d = '0;
                  lights_d = lights_next;
                  if (lights_next == ALL_ON) begin
                     delay_d = delay_load;
                     state_d = StDelay;
                  end
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
         end

         StDelay: begin
            if (false_start) begin
               lights_d = ALL_ON;
               state_d = StFault;
            end else if (i_tick) begin
               // A count of 1 reaches zero on this tick; a zero load goes on the first tick.
               if (delay_q <= DCNT_W'(1)) begin
                  delay_d = '0;
                  lights_d = '0;
                  react_d = '0;
                  state_d = StGo;
               end else begin
                  delay_d = delay_q - 1'b1;
               end
            end
         end

         StGo: begin
            // A tick arriving with the reaction is not counted.
            if (i_reaction) begin
               time_d = react_q;
               valid_d = 1'b1;
               state_d = StIdle;
            end else if (i_tick && (react_q != '1)) begin
               react_d = react_q + 1'b1;
            end
         end

         StFault: begin
            lights_d = ALL_ON;
            if (i_trigger) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset overrides any sequence in flight.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= StIdle;
         lights_q <= '0;
         step_q <= '0;
         delay_q <= '0;
         react_q <= '0;
         time_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lights_q <= lights_d;
         step_q <= step_d;
         delay_q <= delay_d;
         react_q <= react_d;
         time_q <= time_d;
         valid_q <= valid_d;
      end
   end

   assign o_lights       = lights_q;
   assign o_go           = (state_q == StGo);
   assign o_falseStart   = (state_q == StFault);
   assign o_resultValid  = valid_q;
   assign o_reactionTime = time_q;

endmodule

// File: tb/tb_start_light_sequencer.sv
// Self-checking bench for start_light_sequencer: three instances cover the default
// build, slow light stepping, and a narrow saturating reaction counter.
module tb_start_light_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail = 0;

   // Instance A: default parameters.
   logic        a_rst = 1'b1, a_tick = 1'b0, a_trig = 1'b0, a_react = 1'b0;
   logic [9:0]  a_lights;
   logic        a_go, a_fs, a_rv;
   logic [15:0] a_rt;

   start_light_sequencer dut_a (
      .i_clk          (clk),
      .i_rst          (a_rst),
      .i_tick         (a_tick),
      .i_trigger      (a_trig),
      .i_reaction     (a_react),
      .o_lights       (a_lights),
      .o_go           (a_go),
      .o_falseStart   (a_fs),
      .o_resultValid  (a_rv),
      .o_reactionTime (a_rt)
   );

   // Instance B: five lights, four ticks per step.
   logic        b_rst = 1'b1, b_tick = 1'b0, b_trig = 1'b0, b_react = 1'b0;
   logic [4:0]  b_lights;
   logic        b_go, b_fs, b_rv;
   logic [15:0] b_rt;

   start_light_sequencer #(
      .N_LEDS     (5),
      .STEP_TICKS (4)
   ) dut_b (
      .i_clk          (clk),
      .i_rst          (b_rst),
      .i_tick         (b_tick),
      .i_trigger      (b_trig),
      .i_reaction     (b_react),
      .o_lights       (b_lights),
      .o_go           (b_go),
      .o_falseStart   (b_fs),
      .o_resultValid  (b_rv),
      .o_reactionTime (b_rt)
   );

   // Instance C: two lights, short delay, 4-bit reaction counter.
   logic        c_rst = 1'b1, c_tick = 1'b0, c_trig = 1'b0, c_react = 1'b0;
   logic [1:0]  c_lights;
   logic        c_go, c_fs, c_rv;
   logic [3:0]  c_rt;

   start_light_sequencer #(
      .N_LEDS    (2),
      .DELAY_W   (4),
      .MIN_DELAY (2),
      .TIME_W    (4)
   ) dut_c (
      .i_clk          (clk),
      .i_rst          (c_rst),
      .i_tick         (c_tick),
      .i_trigger      (c_trig),
      .i_reaction     (c_react),
      .o_lights       (c_lights),
      .o_go           (c_go),
      .o_falseStart   (c_fs),
      .o_resultValid  (c_rv),
      .o_reactionTime (c_rt)
   );

   typedef struct {
      int arm_wait;       // idle cycles in ARMED before the trigger
      bit hold_trig;      // keep trigger high through the light fill
      int react_ticks;    // ticks in GO before the button
      bit tick_on_react;  // tick coincides with the button
      int exp_time;
   } a_vec_t;

   a_vec_t vecs[5];
   int unsigned qa[$];
   int unsigned qc[$];
   int unsigned last_rt = 0;
   logic a_rv_prev = 1'b0;
   logic c_rv_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Result scoreboards: each valid pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (a_rv) begin
         check("a_pending_results", qa.size(), 1);
         if (qa.size() > 0) check("a_reaction_time", 32'(a_rt), qa.pop_front());
         check("a_valid_single_cycle", 32'(a_rv_prev), 0);
      end
      a_rv_prev = a_rv;
   end

   always @(negedge clk) begin
      if (c_rv) begin
         check("c_pending_results", qc.size(), 1);
         if (qc.size() > 0) check("c_reaction_time", 32'(c_rt), qc.pop_front());
         check("c_valid_single_cycle", 32'(c_rv_prev), 0);
      end
      c_rv_prev = c_rv;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic a_wait_full();
      int n = 0;
      while (a_lights !== 10'h3FF && n < 40) begin
         step();
         n++;
      end
      check("a_lights_full", a_lights, 10'h3FF);
   endtask

   // Count ticks from DELAY entry until GO; lights must stay on throughout.
   task automatic a_wait_go(output int n, output bit lights_ok);
      n = 0;
      lights_ok = 1'b1;
      while (!a_go && n < 400) begin
         step();
         n++;
         if (!a_go && a_lights !== 10'h3FF) lights_ok = 1'b0;
      end
   endtask

   task automatic a_run(input a_vec_t v);
      int n;
      bit ok;
      a_tick = 1'b1;
      repeat (v.arm_wait) step();
      a_trig = 1'b1;
      n = 0;
      while (a_lights !== 10'h001 && n < 20) begin
         step();
         n++;
      end
      check("a_first_light", a_lights, 10'h001);
      check("a_time_held", a_rt, last_rt);
      if (!v.hold_trig) a_trig = 1'b0;
      for (int k = 2; k <= 10; k++) begin
         step();
         check("a_fill", a_lights, (1 << k) - 1);
      end
      a_trig = 1'b0;
      a_wait_go(n, ok);
      check("a_delay_in_range", (n >= 16 && n <= 271), 1);
      check("a_delay_lights_on", ok, 1);
      check("a_go_asserted", a_go, 1);
      check("a_go_lights_off", a_lights, 0);
      repeat (v.react_ticks) step();
      a_react = 1'b1;
      a_tick = v.tick_on_react;
      qa.push_back(v.exp_time);
      step();
      a_react = 1'b0;
      a_tick = 1'b1;
      check("a_result_valid", a_rv, 1);
      check("a_go_cleared", a_go, 0);
      last_rt = v.exp_time;
      step();
      check("a_valid_dropped", a_rv, 0);
      check("a_time_hold", a_rt, last_rt);
   endtask

   initial begin
      int n;
      int ticks;
      int k;
      bit ok;
      logic [4:0] prev;

      vecs[0] = '{0, 1'b0, 37, 1'b1, 37};
      vecs[1] = '{3, 1'b0, 37, 1'b0, 37};
      vecs[2] = '{7, 1'b1, 0, 1'b1, 0};
      vecs[3] = '{1, 1'b0, 5, 1'b0, 5};
      vecs[4] = '{11, 1'b1, 12, 1'b1, 12};

      // Reset state.
      step();
      step();
      check("rst_lights", a_lights, 0);
      check("rst_go", a_go, 0);
      check("rst_false_start", a_fs, 0);
      check("rst_valid", a_rv, 0);
      check("rst_time", a_rt, 0);

      a_rst = 1'b0;
      for (int i = 0; i < 5; i++) a_run(vecs[i]);

      // Reaction during DELAY.
      a_tick = 1'b1;
      a_trig = 1'b1;
      a_wait_full();
      a_trig = 1'b0;
      step();
      step();
      a_react = 1'b1;
      step();
      a_react = 1'b0;
`ifdef FALSE_START_DETECT_EN
      check("fs_asserted", a_fs, 1);
      check("fs_lights_on", a_lights, 10'h3FF);
      check("fs_no_go", a_go, 0);
      repeat (300) step();
      check("fs_held", a_fs, 1);
      check("fs_still_no_go", a_go, 0);
      check("fs_time_unchanged", a_rt, last_rt);
      a_trig = 1'b1;
      step();
      a_trig = 1'b0;
      check("fs_cleared_by_trigger", a_fs, 0);
      check("fs_lights_off", a_lights, 0);
      step();
`else
      check("nofs_false_start_low", a_fs, 0);
      a_wait_go(n, ok);
      check("nofs_delay_lights_on", ok, 1);
      check("nofs_go_reached", a_go, 1);
      repeat (3) step();
      a_react = 1'b1;
      qa.push_back(3);
      step();
      a_react = 1'b0;
      last_rt = 3;
      check("nofs_result_valid", a_rv, 1);
      step();
`endif

      // Reset in the middle of DELAY.
      a_trig = 1'b1;
      a_wait_full();
      a_trig = 1'b0;
      repeat (5) step();
      a_rst = 1'b1;
      step();
      check("mid_rst_lights", a_lights, 0);
      check("mid_rst_go", a_go, 0);
      check("mid_rst_false_start", a_fs, 0);
      check("mid_rst_valid", a_rv, 0);
      check("mid_rst_time", a_rt, 0);
      a_rst = 1'b0;
      last_rt = 0;
      a_run(vecs[0]);

      // Instance B: one light per four ticks, ticks on alternate cycles.
      b_rst = 1'b0;
      b_trig = 1'b1;
      step();
      step();
      b_trig = 1'b0;
      ticks = 0;
      k = 0;
      prev = '0;
      for (int c = 0; c < 60 && k < 5; c++) begin
         b_tick = (c % 2 == 0);
         step();
         if (b_tick) ticks++;
         if (b_lights !== prev) begin
            k++;
            check("b_step_ticks", ticks, 4 * k);
            check("b_lights", b_lights, (1 << k) - 1);
            prev = b_lights;
         end
      end
      b_tick = 1'b0;
      check("b_full", b_lights, 5'h1F);
      check("b_delay_entry_ticks", ticks, 20);

      // Instance C: reaction counter saturates.
      c_rst = 1'b0;
      c_tick = 1'b1;
      c_trig = 1'b1;
      n = 0;
      while (!c_go && n < 60) begin
         step();
         n++;
      end
      c_trig = 1'b0;
      check("c_go_reached", c_go, 1);
      repeat (20) step();
      c_react = 1'b1;
      qc.push_back(15);
      step();
      c_react = 1'b0;
      check("c_result_valid", c_rv, 1);
      step();
      check("c_time_saturated_hold", c_rt, 15);

      repeat (3) step();
      check("a_queue_drained", qa.size(), 0);
      check("c_queue_drained", qc.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
